// File: rtl/snell_refract_angle.sv
// rtl/snell_refract_angle.sv - sequential Snell refraction angle: sine ROM, multiply, restoring divide, arcsine search
module snell_refract_angle (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] n1,
  input  logic [3:0] n2,
  input  logic [6:0] theeta1,
  output logic [6:0] theeta2,
  output logic       tir,
  output logic       err,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIN,
    S_MUL,
    S_DIV,
    S_CHK,
    S_ASIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]  r_n1;
  logic [3:0]  r_n2;
  logic [6:0]  r_th1;
  logic [8:0]  r_s1;
  logic [11:0] r_dvd;
  logic [3:0]  r_rem;
  logic [11:0] r_quo;
  logic [3:0]  r_cnt;
  logic [6:0]  r_a;
  logic [2:0]  r_bit;

  logic [6:0]  r_theeta2;
  logic        r_tir;
  logic        r_err;
  logic        r_busy;
  logic        r_done;

  logic [6:0]  w_trial;
  logic [6:0]  w_rom_addr;
  logic [8:0]  w_rom_q;
  logic        w_accept;
  logic [6:0]  w_a_next;
  logic        w_err;
  logic [12:0] w_prod;
  logic [4:0]  w_rem_sh;
  logic        w_ge;
  logic [4:0]  w_rem_nx;
  logic        w_is_tir;

  // round(sin(a deg) * 256); addresses above 90 never reach an accepted result
  function automatic logic [8:0] sin_lut(input logic [6:0] a);
    case (a)
      7'd0:  sin_lut = 9'd0;   7'd1:  sin_lut = 9'd4;   7'd2:  sin_lut = 9'd9;   7'd3:  sin_lut = 9'd13;
      7'd4:  sin_lut = 9'd18;  7'd5:  sin_lut = 9'd22;  7'd6:  sin_lut = 9'd27;  7'd7:  sin_lut = 9'd31;
      7'd8:  sin_lut = 9'd36;  7'd9:  sin_lut = 9'd40;  7'd10: sin_lut = 9'd44;  7'd11: sin_lut = 9'd49;
      7'd12: sin_lut = 9'd53;  7'd13: sin_lut = 9'd58;  7'd14: sin_lut = 9'd62;  7'd15: sin_lut = 9'd66;
      7'd16: sin_lut = 9'd71;  7'd17: sin_lut = 9'd75;  7'd18: sin_lut = 9'd79;  7'd19: sin_lut = 9'd83;
      7'd20: sin_lut = 9'd88;  7'd21: sin_lut = 9'd92;  7'd22: sin_lut = 9'd96;  7'd23: sin_lut = 9'd100;
      7'd24: sin_lut = 9'd104; 7'd25: sin_lut = 9'd108; 7'd26: sin_lut = 9'd112; 7'd27: sin_lut = 9'd116;
      7'd28: sin_lut = 9'd120; 7'd29: sin_lut = 9'd124; 7'd30: sin_lut = 9'd128; 7'd31: sin_lut = 9'd132;
      7'd32: sin_lut = 9'd136; 7'd33: sin_lut = 9'd139; 7'd34: sin_lut = 9'd143; 7'd35: sin_lut = 9'd147;
      7'd36: sin_lut = 9'd150; 7'd37: sin_lut = 9'd154; 7'd38: sin_lut = 9'd158; 7'd39: sin_lut = 9'd161;
      7'd40: sin_lut = 9'd165; 7'd41: sin_lut = 9'd168; 7'd42: sin_lut = 9'd171; 7'd43: sin_lut = 9'd175;
      7'd44: sin_lut = 9'd178; 7'd45: sin_lut = 9'd181; 7'd46: sin_lut = 9'd184; 7'd47: sin_lut = 9'd187;
      7'd48: sin_lut = 9'd190; 7'd49: sin_lut = 9'd193; 7'd50: sin_lut = 9'd196; 7'd51: sin_lut = 9'd199;
      7'd52: sin_lut = 9'd202; 7'd53: sin_lut = 9'd204; 7'd54: sin_lut = 9'd207; 7'd55: sin_lut = 9'd210;
      7'd56: sin_lut = 9'd212; 7'd57: sin_lut = 9'd215; 7'd58: sin_lut = 9'd217; 7'd59: sin_lut = 9'd219;
      7'd60: sin_lut = 9'd222; 7'd61: sin_lut = 9'd224; 7'd62: sin_lut = 9'd226; 7'd63: sin_lut = 9'd228;
      7'd64: sin_lut = 9'd230; 7'd65: sin_lut = 9'd232; 7'd66: sin_lut = 9'd234; 7'd67: sin_lut = 9'd236;
      7'd68: sin_lut = 9'd237; 7'd69: sin_lut = 9'd239; 7'd70: sin_lut = 9'd241; 7'd71: sin_lut = 9'd242;
      7'd72: sin_lut = 9'd243; 7'd73: sin_lut = 9'd245; 7'd74: sin_lut = 9'd246; 7'd75: sin_lut = 9'd247;
      7'd76: sin_lut = 9'd248; 7'd77: sin_lut = 9'd249; 7'd78: sin_lut = 9'd250; 7'd79: sin_lut = 9'd251;
      7'd80: sin_lut = 9'd252; 7'd81: sin_lut = 9'd253; 7'd82: sin_lut = 9'd254; 7'd83: sin_lut = 9'd254;
      7'd84: sin_lut = 9'd255; 7'd85: sin_lut = 9'd255; 7'd86: sin_lut = 9'd255; 7'd87: sin_lut = 9'd256;
      7'd88: sin_lut = 9'd256; 7'd89: sin_lut = 9'd256; 7'd90: sin_lut = 9'd256;
      default: sin_lut = 9'd256;
    endcase
  endfunction

  // one shared ROM port: forward lookup in SIN, trial lookups during the arcsine search
  assign w_trial    = r_a | (7'd1 << r_bit);
  assign w_rom_addr = (r_state == S_SIN) ? r_th1 : w_trial;
  assign w_rom_q    = sin_lut(w_rom_addr);
  assign w_accept   = (w_trial <= 7'd90) && ({3'b000, w_rom_q} <= r_quo);
  assign w_a_next   = w_accept ? w_trial : r_a;

  assign w_err    = (r_n2 == 4'd0) || (r_th1 > 7'd90);
  assign w_prod   = 13'(r_n1) * 13'(r_s1);
  assign w_is_tir = (r_quo > 12'd256);

  // q3.10 / q2.2 into q1.8 is the plain integer quotient P / N2; remainder stays below n2
  assign w_rem_sh = {r_rem, r_dvd[11]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_n2});
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_n2}) : w_rem_sh;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state sequencing
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_SIN;
      S_SIN:  w_next = w_err ? S_IDLE : S_MUL;
      S_MUL:  w_next = S_DIV;
      S_DIV:  if (r_cnt == 4'd11) w_next = S_CHK;
      S_CHK:  w_next = w_is_tir ? S_IDLE : S_ASIN;
      S_ASIN: if (r_bit == 3'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // datapath: operand capture, multiply, divide iterations, arcsine search
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n1  <= '0;
      r_n2  <= '0;
      r_th1 <= '0;
      r_s1  <= '0;
      r_dvd <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_a   <= '0;
      r_bit <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_n1  <= n1;
          r_n2  <= n2;
          r_th1 <= theeta1;
        end
        S_SIN: r_s1 <= w_rom_q;
        S_MUL: begin
          // p never exceeds 15*256, so bit 12 is zero and preloading it as remainder is exact
          r_dvd <= w_prod[11:0];
          r_rem <= {3'b000, w_prod[12]};
          r_quo <= '0;
          r_cnt <= '0;
        end
        S_DIV: begin
          r_dvd <= {r_dvd[10:0], 1'b0};
          r_rem <= w_rem_nx[3:0];
          r_quo <= {r_quo[10:0], w_ge};
          r_cnt <= r_cnt + 4'd1;
        end
        S_CHK: begin
          r_a   <= '0;
          r_bit <= 3'd6;
        end
        S_ASIN: begin
          r_a   <= w_a_next;
          r_bit <= r_bit - 3'd1;
        end
        default: ;
      endcase
    end
  end

  // registered outputs; results hold until the next done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_theeta2 <= '0;
      r_tir     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) r_busy <= 1'b1;
        S_SIN: if (w_err) begin
          r_theeta2 <= '0;
          r_tir     <= 1'b0;
          r_err     <= 1'b1;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
        end
        S_CHK: if (w_is_tir) begin
          r_theeta2 <= '0;
          r_tir     <= 1'b1;
          r_err     <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
        end
        S_ASIN: if (r_bit == 3'd0) begin
          r_theeta2 <= w_a_next;
          r_tir     <= 1'b0;
          r_err     <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign theeta2 = r_theeta2;
  assign tir     = r_tir;
  assign err     = r_err;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_snell_refract_angle.sv
// tb/tb_snell_refract_angle.sv - directed-vector self-checking bench for snell_refract_angle
module tb_snell_refract_angle;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] n1;
  logic [3:0] n2;
  logic [6:0] theeta1;
  logic [6:0] theeta2;
  logic       tir;
  logic       err;
  logic       busy;
  logic       done;

  int n_checks;
  int n_errors;

  snell_refract_angle dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .n1      (n1),
    .n2      (n2),
    .theeta1 (theeta1),
    .theeta2 (theeta2),
    .tir     (tir),
    .err     (err),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one operation and check result, latency, busy/done behaviour and hold.
  task automatic run(input string tag, input logic [3:0] a_n1, input logic [3:0] a_n2,
                     input logic [6:0] a_th, input int e_th, input int e_tir,
                     input int e_err, input int e_lat);
    int lat;
    lat = 0;
    @(negedge clk);
    n1 = a_n1; n2 = a_n2; theeta1 = a_th; start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".busy_on"}, busy, 1);
    @(negedge clk);
    start = 1'b0;
    n1 = ~a_n1; n2 = ~a_n2; theeta1 = 7'd77;
    #4;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, ".latency"}, lat, e_lat);
    chk({tag, ".theeta2"}, theeta2, e_th);
    chk({tag, ".tir"}, tir, e_tir);
    chk({tag, ".err"}, err, e_err);
    chk({tag, ".busy_off"}, busy, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".hold"}, theeta2, e_th);
  endtask

  initial begin
    int ndone;
    int th_at_done;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; n1 = '0; n2 = '0; theeta1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.theeta2", theeta2, 0);
    chk("reset.tir", tir, 0);
    chk("reset.err", err, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // p=512, q=64 -> 14
    run("normal30", 4'b0100, 4'b1000, 7'd30, 14, 0, 0, 22);
    // q=181 -> 45
    run("equal45", 4'b0110, 4'b0110, 7'd45, 45, 0, 0, 22);
    // q=256 -> 90
    run("equal90", 4'b0110, 4'b0110, 7'd90, 90, 0, 0, 22);
    run("equal0", 4'b0110, 4'b0110, 7'd0, 0, 0, 0, 22);
    // p=640, q=160 -> 38 (S(38)=158, S(39)=161)
    run("n125", 4'b0101, 4'b0100, 7'd30, 38, 0, 0, 22);
    // p=616, q=floor(616/3)=205 -> 53 (S(53)=204, S(54)=207)
    run("floor", 4'b0111, 4'b0011, 7'd20, 53, 0, 0, 22);
    // q=444 > 256
    run("tir60", 4'b1000, 4'b0100, 7'd60, 0, 1, 0, 15);
    run("err_n2", 4'b0100, 4'b0000, 7'd30, 0, 0, 1, 1);
    run("err_th", 4'b0100, 4'b0100, 7'd95, 0, 0, 1, 1);

    // reset mid-operation: err is still 1 from the previous result
    @(negedge clk);
    n1 = 4'b0100; n2 = 4'b1000; theeta1 = 7'd30; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.theeta2", theeta2, 0);
    chk("abort.err", err, 0);
    chk("abort.tir", tir, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort.no_done", ndone, 0);
    run("after_rst", 4'b0100, 4'b1000, 7'd30, 14, 0, 0, 22);

    // second start with other operands during busy must be ignored
    @(negedge clk);
    n1 = 4'b0110; n2 = 4'b0110; theeta1 = 7'd45; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n1 = 4'b1000; n2 = 4'b0100; theeta1 = 7'd60; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    th_at_done = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        th_at_done = theeta2;
      end
    end
    chk("ignore.ndone", ndone, 1);
    chk("ignore.theeta2", th_at_done, 45);
    chk("ignore.tir", tir, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
